// File: rtl/jtag_scan_master_if.sv
// Control-side handshake for the JTAG scan master: request, scan data and status.
interface jtag_scan_master_if #(
  parameter int MAX_LEN = 32
);
  logic               Start;
  logic               Is_IR;
  logic [5:0]         Length;
  logic [MAX_LEN-1:0] Data_in;
  logic               Busy;
  logic               Done;
  logic [MAX_LEN-1:0] Data_out;

  modport master (
    output Start, Is_IR, Length, Data_in,
    input  Busy, Done, Data_out
  );

  modport slave (
    input  Start, Is_IR, Length, Data_in,
    output Busy, Done, Data_out
  );
endinterface

// File: rtl/jtag_scan_master.sv
// JTAG initiator: runs single IR/DR scans on a target TAP at CLK/2 and
// always parks the TAP in Run-Test/Idle between operations.
module jtag_scan_master #(
  parameter int MAX_LEN = 32
) (
  input  logic              CLK,
  input  logic              RST_n,
  jtag_scan_master_if.slave ctl,
  input  logic              TDO,
  output logic              TCK_out,
  output logic              TMS,
  output logic              TDI
);

  typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, FIN} state_t;

  state_t             state_q, state_n;
  logic [5:0]         cnt_q, cnt_n;
  logic [5:0]         len_q, len_n;
  logic               is_ir_q, is_ir_n;
  logic [MAX_LEN-1:0] din_q, din_n;
  logic [MAX_LEN-1:0] dout_q, dout_n;
  logic               tck_q, tck_n;
  logic               tms_q, tms_n;
  logic               tdi_q, tdi_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               len_ok;
  logic [5:0]         pre_last;
  logic [5:0]         pre_ones;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      len_q   <= '0;
      is_ir_q <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      len_q   <= len_n;
      is_ir_q <= is_ir_n;
      din_q   <= din_n;
      dout_q  <= dout_n;
      tck_q   <= tck_n;
      tms_q   <= tms_n;
      tdi_q   <= tdi_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Every TAP period is two CLKs: tck_q=0 edge raises TCK and samples TDO,
  // tck_q=1 edge drops TCK and moves TMS/TDI on to the next period.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    len_n    = len_q;
    is_ir_n  = is_ir_q;
    din_n    = din_q;
    dout_n   = dout_q;
    tck_n    = tck_q;
    tms_n    = tms_q;
    tdi_n    = tdi_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    len_ok   = (ctl.Length != 6'd0) && (int'(ctl.Length) <= MAX_LEN);
    pre_last = is_ir_q ? 6'd3 : 6'd2;
    pre_ones = is_ir_q ? 6'd2 : 6'd1;

    unique case (state_q)
      INIT: begin
        // Busy still low means this is the first CLK after reset: open period 0.
        if (!busy_q) begin
          busy_n = 1'b1;
        end else if (!tck_q) begin
          tck_n = 1'b1;
        end else begin
          tck_n = 1'b0;
          if (cnt_q == 6'd5) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            cnt_n   = '0;
            tms_n   = 1'b0;
          end else begin
            cnt_n = cnt_q + 6'd1;
            tms_n = (cnt_q != 6'd4);
          end
        end
      end

      IDLE: begin
        tck_n = 1'b0;
        tms_n = 1'b0;
        if (ctl.Start && len_ok) begin
          state_n = PRE;
          is_ir_n = ctl.Is_IR;
          len_n   = ctl.Length;
          din_n   = ctl.Data_in;
          dout_n  = '0;
          busy_n  = 1'b1;
          cnt_n   = '0;
          tms_n   = 1'b1;
        end
      end

      PRE: begin
        if (!tck_q) begin
          tck_n = 1'b1;
        end else begin
          tck_n = 1'b0;
          if (cnt_q == pre_last) begin
            state_n = SHIFT;
            cnt_n   = '0;
            tms_n   = (len_q == 6'd1);
            tdi_n   = din_q[0];
          end else begin
            cnt_n = cnt_q + 6'd1;
            tms_n = ((cnt_q + 6'd1) < pre_ones);
          end
        end
      end

      SHIFT: begin
        if (!tck_q) begin
          tck_n  = 1'b1;
          dout_n = dout_q | ({{(MAX_LEN-1){1'b0}}, TDO} << cnt_q);
        end else begin
          tck_n = 1'b0;
          if (cnt_q == len_q - 6'd1) begin
            state_n = POST;
            cnt_n   = '0;
            tms_n   = 1'b1;
            tdi_n   = 1'b0;
          end else begin
            cnt_n = cnt_q + 6'd1;
            din_n = din_q >> 1;
            tdi_n = din_q[1];
            tms_n = ((cnt_q + 6'd2) == len_q);
          end
        end
      end

      POST: begin
        if (!tck_q) begin
          tck_n = 1'b1;
        end else begin
          tck_n = 1'b0;
          tms_n = 1'b0;
          if (cnt_q == 6'd0) begin
            cnt_n = 6'd1;
          end else begin
            state_n = FIN;
            cnt_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end

      FIN: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        tck_n   = 1'b0;
      end
    endcase
  end

  assign TCK_out      = tck_q;
  assign TMS          = tms_q;
  assign TDI          = tdi_q;
  assign ctl.Busy     = busy_q;
  assign ctl.Done     = done_q;
  assign ctl.Data_out = dout_q;

endmodule
